// File: rtl/fsm_phase_responder_pkg.sv
// Shared sequencer state codes and the per-phase done-flag payload.
package fsm_phase_responder_pkg;

  localparam int unsigned FSM_BITS = 5;

  localparam logic [FSM_BITS-1:0] ST_IDLE        = FSM_BITS'(0);
  localparam logic [FSM_BITS-1:0] ST_FIRST_LOAD  = FSM_BITS'(1);
  localparam logic [FSM_BITS-1:0] ST_CPB_0       = FSM_BITS'(2);
  localparam logic [FSM_BITS-1:0] ST_CPB_1       = FSM_BITS'(3);
  localparam logic [FSM_BITS-1:0] ST_CPB_2       = FSM_BITS'(4);
  localparam logic [FSM_BITS-1:0] ST_CPB_LOADNEW = FSM_BITS'(5);
  localparam logic [FSM_BITS-1:0] ST_CPB_3       = FSM_BITS'(6);
  localparam logic [FSM_BITS-1:0] ST_CPB_4       = FSM_BITS'(7);

  // One bit per phase, ordered like the state codes 1..7.
  typedef struct packed {
    logic cpb4;
    logic cpb3;
    logic cpbldnew;
    logic cpb2;
    logic cpb1;
    logic cpb0;
    logic firstload;
  } phase_flags_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_LOAD,
    PH_CPB
  } phase_kind_t;

  // Which kind of work a sequencer state asks for; unknown codes do nothing.
  function automatic phase_kind_t phase_kind(input logic [FSM_BITS-1:0] s);
    phase_kind_t k;
    k = PH_NONE;
    case (s)
      ST_IDLE:                       k = PH_NONE;
      ST_FIRST_LOAD, ST_CPB_LOADNEW: k = PH_LOAD;
      ST_CPB_0, ST_CPB_1, ST_CPB_2,
      ST_CPB_3, ST_CPB_4:            k = PH_CPB;
      default:                       k = PH_NONE;
    endcase
    return k;
  endfunction

  // One-hot done flag for a completed phase.
  function automatic phase_flags_t phase_flag(input logic [FSM_BITS-1:0] s);
    phase_flags_t f;
    f = '0;
    case (s)
      ST_FIRST_LOAD:  f.firstload = 1'b1;
      ST_CPB_0:       f.cpb0      = 1'b1;
      ST_CPB_1:       f.cpb1      = 1'b1;
      ST_CPB_2:       f.cpb2      = 1'b1;
      ST_CPB_LOADNEW: f.cpbldnew  = 1'b1;
      ST_CPB_3:       f.cpb3      = 1'b1;
      ST_CPB_4:       f.cpb4      = 1'b1;
      default:        f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fsm_phase_responder_if.sv
// Sequencer/datapath <-> responder handshake bundle.
interface fsm_phase_responder_if #(
  parameter int unsigned PASS_BITS = 8
);
  import fsm_phase_responder_pkg::*;

  logic [FSM_BITS-1:0]  cur_state;
  logic                 ld_valid;
  logic                 ld_ready;
  logic                 cpb_stall;
  logic                 flag_firstload_end;
  logic                 flag_cpb0_end;
  logic                 flag_cpb1_end;
  logic                 flag_cpb2_end;
  logic                 flag_cpb3_end;
  logic                 flag_cpb4_end;
  logic                 flag_cpbldnew_end;
  logic                 phase_active;
  logic [PASS_BITS-1:0] pass_cnt;

  modport master (
    output cur_state, ld_valid, cpb_stall,
    input  ld_ready, flag_firstload_end, flag_cpb0_end, flag_cpb1_end,
           flag_cpb2_end, flag_cpb3_end, flag_cpb4_end, flag_cpbldnew_end,
           phase_active, pass_cnt
  );

  modport slave (
    input  cur_state, ld_valid, cpb_stall,
    output ld_ready, flag_firstload_end, flag_cpb0_end, flag_cpb1_end,
           flag_cpb2_end, flag_cpb3_end, flag_cpb4_end, flag_cpbldnew_end,
           phase_active, pass_cnt
  );

endinterface

// File: rtl/fsm_phase_responder_phase_counter.sv
// Shared beat/cycle counter with sync clear and a runtime terminal count.
module fsm_phase_responder_phase_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         tc_hit
);

  logic [W-1:0] cnt_q;

  assign tc_hit = (cnt_q == tc);

  // Count enabled events; return to zero on the terminal event so it never passes tc.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc_hit ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/fsm_phase_responder.sv
// Far end of the phase-sequencer handshake: runs load beats or compute cycles
// for the current phase and returns one done pulse per completed phase.
module fsm_phase_responder
  import fsm_phase_responder_pkg::*;
#(
  parameter int unsigned LOAD_BEATS = 16,
  parameter int unsigned CPB_CYCLES = 32,
  parameter int unsigned PASS_BITS  = 8
) (
  input logic                  clk,
  input logic                  reset,
  fsm_phase_responder_if.slave bus
);

  localparam int unsigned MAX_CNT = (LOAD_BEATS > CPB_CYCLES) ? LOAD_BEATS : CPB_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_CPB,
    R_DONE
  } rstate_t;

  rstate_t              rstate_q;
  logic [FSM_BITS-1:0]  st_q;
  logic [FSM_BITS-1:0]  phase_q;
  logic                 ld_ready_q;
  logic                 phase_active_q;
  phase_flags_t         flags_q;
  logic [PASS_BITS-1:0] pass_q;

  logic                 entry_c;
  logic                 cnt_en_c;
  logic [CNT_W-1:0]     tc_c;
  logic                 tc_hit;
  logic                 done_c;

  assign entry_c = (bus.cur_state != st_q);

  // Select what the counter is counting and where it stops.
  always_comb begin
    cnt_en_c = 1'b0;
    tc_c     = CNT_W'(CPB_CYCLES - 1);
    case (rstate_q)
      R_LOAD: begin
        cnt_en_c = ld_ready_q & bus.ld_valid;
        tc_c     = CNT_W'(LOAD_BEATS - 1);
      end
      R_CPB:   cnt_en_c = ~bus.cpb_stall;
      default: cnt_en_c = 1'b0;
    endcase
    done_c = cnt_en_c & tc_hit & ~entry_c;
  end

  fsm_phase_responder_phase_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (entry_c),
    .en     (cnt_en_c),
    .tc     (tc_c),
    .tc_hit (tc_hit)
  );

  // Responder FSM; a phase entry overrides every other transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_q       <= R_IDLE;
      st_q           <= ST_IDLE;
      phase_q        <= ST_IDLE;
      ld_ready_q     <= 1'b0;
      phase_active_q <= 1'b0;
      flags_q        <= '0;
      pass_q         <= '0;
    end else begin
      st_q    <= bus.cur_state;
      flags_q <= '0;
      if (entry_c) begin
        phase_q <= bus.cur_state;
        case (phase_kind(bus.cur_state))
          PH_LOAD: begin
            rstate_q       <= R_LOAD;
            ld_ready_q     <= 1'b1;
            phase_active_q <= 1'b1;
          end
          PH_CPB: begin
            rstate_q       <= R_CPB;
            ld_ready_q     <= 1'b0;
            phase_active_q <= 1'b1;
          end
          default: begin
            rstate_q       <= R_IDLE;
            ld_ready_q     <= 1'b0;
            phase_active_q <= 1'b0;
          end
        endcase
      end else if (done_c) begin
        rstate_q       <= R_DONE;
        ld_ready_q     <= 1'b0;
        phase_active_q <= 1'b0;
        flags_q        <= phase_flag(phase_q);
        if (phase_q == ST_CPB_4) begin
          pass_q <= pass_q + PASS_BITS'(1);
        end
      end
    end
  end

  assign bus.ld_ready           = ld_ready_q;
  assign bus.phase_active       = phase_active_q;
  assign bus.pass_cnt           = pass_q;
  assign bus.flag_firstload_end = flags_q.firstload;
  assign bus.flag_cpb0_end      = flags_q.cpb0;
  assign bus.flag_cpb1_end      = flags_q.cpb1;
  assign bus.flag_cpb2_end      = flags_q.cpb2;
  assign bus.flag_cpbldnew_end  = flags_q.cpbldnew;
  assign bus.flag_cpb3_end      = flags_q.cpb3;
  assign bus.flag_cpb4_end      = flags_q.cpb4;

endmodule

// File: tb/tb_fsm_phase_responder.sv
// Directed bench for fsm_phase_responder with a flag-pulse scoreboard.
module tb_fsm_phase_responder;
  import fsm_phase_responder_pkg::*;

  localparam int unsigned LB = 4;
  localparam int unsigned CC = 8;
  localparam int unsigned PB = 2;

  typedef struct {
    int idx;
    int cyc;
    int pass;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];

  fsm_phase_responder_if #(.PASS_BITS(PB)) bus ();

  fsm_phase_responder #(
    .LOAD_BEATS (LB),
    .CPB_CYCLES (CC),
    .PASS_BITS  (PB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle N is the interval following the Nth rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int state, input int fcyc, input int pass);
    exp_t e;
    e.idx  = state - 1;
    e.cyc  = fcyc;
    e.pass = pass;
    sb.push_back(e);
  endtask

  // Monitor: every flag pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [6:0] f;
    exp_t       e;
    f = {bus.flag_cpb4_end, bus.flag_cpb3_end, bus.flag_cpbldnew_end, bus.flag_cpb2_end,
         bus.flag_cpb1_end, bus.flag_cpb0_end, bus.flag_firstload_end};
    if (f != 7'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_flag", 32'(f), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("flag_which", 32'(f), 32'(7'd1 << e.idx));
        chk("flag_cycle", 32'(cyc), 32'(e.cyc));
        chk("pass_at_flag", 32'(bus.pass_cnt), 32'(e.pass));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f;
    int seq[8];
    int pexp[5];
    seq  = '{1, 2, 3, 4, 5, 6, 7, 2};
    pexp = '{1, 2, 3, 0, 1};
    n_vec = 0;
    n_bad = 0;
    reset         = 1'b1;
    bus.cur_state = ST_IDLE;
    bus.ld_valid  = 1'b0;
    bus.cpb_stall = 1'b0;

    // Reset values.
    to_cycle(2);
    @(negedge clk);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_active", 32'(bus.phase_active), 32'd0);
    chk("rst_pass", 32'(bus.pass_cnt), 32'd0);
    to_cycle(3);
    reset = 1'b0;

    // FIRST_LOAD with back-to-back beats: ready 11..14, flag at 15.
    to_cycle(10);
    bus.cur_state = ST_FIRST_LOAD;
    bus.ld_valid  = 1'b1;
    push(1, 15, 0);
    @(negedge clk);
    chk("t1_ready_c10", 32'(bus.ld_ready), 32'd0);
    for (int c = 11; c <= 14; c++) begin
      to_cycle(c);
      @(negedge clk);
      chk("t1_ready_hi", 32'(bus.ld_ready), 32'd1);
    end
    to_cycle(15);
    @(negedge clk);
    chk("t1_ready_c15", 32'(bus.ld_ready), 32'd0);
    chk("t1_active_c15", 32'(bus.phase_active), 32'd0);
    to_cycle(16);
    bus.ld_valid = 1'b0;

    // CPB_0 with two stall cycles: flag at 31.
    to_cycle(20);
    bus.cur_state = ST_CPB_0;
    push(2, 31, 0);
    to_cycle(21);
    @(negedge clk);
    chk("t2_active", 32'(bus.phase_active), 32'd1);
    chk("t2_ready", 32'(bus.ld_ready), 32'd0);
    to_cycle(23);
    bus.cpb_stall = 1'b1;
    to_cycle(25);
    bus.cpb_stall = 1'b0;
    to_cycle(31);
    @(negedge clk);
    chk("t2_active_done", 32'(bus.phase_active), 32'd0);

    // Abandon CPB_1 after 3 counted cycles: no flag.
    to_cycle(40);
    bus.cur_state = ST_CPB_1;
    to_cycle(43);
    @(negedge clk);
    chk("t5_active_mid", 32'(bus.phase_active), 32'd1);
    to_cycle(44);
    bus.cur_state = ST_IDLE;
    to_cycle(45);
    @(negedge clk);
    chk("t5_ready", 32'(bus.ld_ready), 32'd0);
    chk("t5_active", 32'(bus.phase_active), 32'd0);

    // Reset during a load with 2 beats taken; re-entry needs 4 fresh beats.
    to_cycle(60);
    bus.cur_state = ST_FIRST_LOAD;
    bus.ld_valid  = 1'b1;
    to_cycle(63);
    reset = 1'b1;
    to_cycle(64);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 32'(bus.ld_ready), 32'd0);
    chk("t6_active", 32'(bus.phase_active), 32'd0);
    chk("t6_pass", 32'(bus.pass_cnt), 32'd0);
    push(1, 69, 0);
    to_cycle(65);
    @(negedge clk);
    chk("t6_ready_again", 32'(bus.ld_ready), 32'd1);
    to_cycle(75);
    bus.cur_state = ST_IDLE;

    // Full sequencer loop; next phase enters the cycle after each flag.
    to_cycle(80);
    bus.ld_valid = 1'b1;
    n = 80;
    for (int i = 0; i < 8; i++) begin
      to_cycle(n);
      bus.cur_state = FSM_BITS'(seq[i]);
      f = n + ((seq[i] == 1 || seq[i] == 5) ? LB : CC) + 1;
      push(seq[i], f, (i >= 6) ? 1 : 0);
      n = f + 1;
    end
    to_cycle(n);
    bus.cur_state = ST_IDLE;
    bus.ld_valid  = 1'b0;
    to_cycle(n + 1);
    @(negedge clk);
    chk("t3_pass", 32'(bus.pass_cnt), 32'd1);

    // Fresh reset, then five CPB_4 completions: pass_cnt 1,2,3,0,1.
    to_cycle(n + 3);
    reset = 1'b1;
    to_cycle(n + 5);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_pass_rst", 32'(bus.pass_cnt), 32'd0);
    n = n + 6;
    for (int i = 0; i < 5; i++) begin
      to_cycle(n);
      bus.cur_state = ST_CPB_4;
      f = n + CC + 1;
      push(7, f, pexp[i]);
      to_cycle(f + 1);
      bus.cur_state = ST_IDLE;
      n = f + 2;
    end

    // Unknown state code stays idle.
    to_cycle(n);
    bus.cur_state = FSM_BITS'(9);
    to_cycle(n + 1);
    @(negedge clk);
    chk("unk_active", 32'(bus.phase_active), 32'd0);
    chk("unk_ready", 32'(bus.ld_ready), 32'd0);
    to_cycle(n + 12);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
